// File: rtl/coef_packer.sv
// coef_packer: collects 2-bit coefficients serially, lowest index first, and
// repacks them into two N-bit bit-plane words (plane0 = LSBs, plane1 = MSBs).
// One completed word may wait in the shift registers while the output slot is busy.
module coef_packer #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   coef_in,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] plane0,
    output logic [N-1:0] plane1
);

    localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_HOLD    = 1'b1;

    logic [0:0]    state, state_n;
    logic [N-1:0]  sh0, sh0_n;
    logic [N-1:0]  sh1, sh1_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [N-1:0]  plane0_n, plane1_n;
    logic          out_valid_n;
    logic          in_ready_n;

    logic          slot_free;
    logic          accept;
    logic          complete;
    logic [N-1:0]  shift0, shift1;
    logic [N-1:0]  adj0, adj1;
    logic [CW-1:0] shamt;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_COLLECT;
            sh0       <= '0;
            sh1       <= '0;
            cnt       <= '0;
            plane0    <= '0;
            plane1    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_n;
            sh0       <= sh0_n;
            sh1       <= sh1_n;
            cnt       <= cnt_n;
            plane0    <= plane0_n;
            plane1    <= plane1_n;
            out_valid <= out_valid_n;
            in_ready  <= in_ready_n;
        end
    end

    // Next-state: shift in coefficients, complete words, move them to the output slot
    always_comb begin
        state_n     = state;
        sh0_n       = sh0;
        sh1_n       = sh1;
        cnt_n       = cnt;
        plane0_n    = plane0;
        plane1_n    = plane1;
        out_valid_n = out_valid;

        slot_free = !out_valid || out_ready;
        accept    = in_valid && in_ready;
        shift0    = {coef_in[0], sh0[N-1:1]};
        shift1    = {coef_in[1], sh1[N-1:1]};
        // A short word is right-aligned; a full word needs a zero shift.
        shamt     = LAST_IDX - cnt;
        adj0      = shift0 >> shamt;
        adj1      = shift1 >> shamt;
        complete  = accept && ((cnt == LAST_IDX) || in_last);

        if (out_valid && out_ready) begin
            out_valid_n = 1'b0;
        end

        case (state)
            ST_COLLECT: begin
                if (accept) begin
                    if (complete) begin
                        cnt_n = '0;
                        if (slot_free) begin
                            plane0_n    = adj0;
                            plane1_n    = adj1;
                            out_valid_n = 1'b1;
                            sh0_n       = '0;
                            sh1_n       = '0;
                        end else begin
                            sh0_n   = adj0;
                            sh1_n   = adj1;
                            state_n = ST_HOLD;
                        end
                    end else begin
                        sh0_n = shift0;
                        sh1_n = shift1;
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (slot_free) begin
                    plane0_n    = sh0;
                    plane1_n    = sh1;
                    out_valid_n = 1'b1;
                    sh0_n       = '0;
                    sh1_n       = '0;
                    cnt_n       = '0;
                    state_n     = ST_COLLECT;
                end
            end
            default: begin
                state_n = ST_COLLECT;
            end
        endcase

        in_ready_n = (state_n == ST_COLLECT);
    end

endmodule
